// File: rtl/stencil_seq.sv
// Row-command sequencer for the stencil engine. It issues one read command per grid row and one
// write command per interior row, throttled to the line-buffer depth, then reports DONE.
module stencil_seq #(
  parameter int WORD_BYTES = 4,
  parameter int RD_AHEAD   = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [15:0] STENCIL_SIZE,
  input  logic [31:0] STENCIL_SRC,
  input  logic [31:0] STENCIL_DST,
  input  logic        STENCIL_GO,
  output logic        STENCIL_DONE,
  output logic        RD_CMD_VALID,
  input  logic        RD_CMD_READY,
  output logic [31:0] RD_CMD_ADDR,
  output logic [15:0] RD_CMD_LEN,
  output logic        WR_CMD_VALID,
  input  logic        WR_CMD_READY,
  output logic [31:0] WR_CMD_ADDR,
  output logic [15:0] WR_CMD_LEN,
  input  logic        WR_CMPL
);

  localparam int SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] n_q;
  logic [31:0] stride_q, rd_addr_q, wr_addr_q, stride_in;
  logic [16:0] rd_issued, wr_issued, wr_done, n_ext, n_m2;
  logic        rd_vld_p1, wr_vld_p1, done_q;
  logic        rd_vld_nxt, wr_vld_nxt, rd_hs, wr_hs, all_issued, active;

  // Read row may be requested while it exists and the line buffer has a free row.
  function automatic logic rd_elig(input logic [16:0] issued, input logic [16:0] retired,
                                   input logic [16:0] rows);
    return (issued < rows) && ((issued - retired) < 17'(RD_AHEAD));
  endfunction

  // Write row issued+1 needs its upper neighbour (row issued+2) already requested.
  function automatic logic wr_elig(input logic [16:0] issued, input logic [16:0] rd_cnt,
                                   input logic [16:0] rows_m2);
    return (issued < rows_m2) && (rd_cnt >= issued + 17'd3);
  endfunction

  assign n_ext      = {1'b0, n_q};
  assign n_m2       = n_ext - 17'd2;
  assign stride_in  = 32'(STENCIL_SIZE) << SHIFT;
  assign rd_hs      = rd_vld_p1 & RD_CMD_READY;
  assign wr_hs      = wr_vld_p1 & WR_CMD_READY;
  assign active     = (state == RUN) || (state == DRAIN);
  assign all_issued = (rd_issued == n_ext) && (wr_issued == n_m2) && !rd_vld_p1 && !wr_vld_p1;

  always_comb begin
    state_nxt  = state;
    rd_vld_nxt = 1'b0;
    wr_vld_nxt = 1'b0;
    case (state)
      IDLE:  if (STENCIL_GO) state_nxt = (STENCIL_SIZE >= 16'd3) ? RUN : FIN;
      RUN: begin
        if (all_issued) state_nxt = (wr_done == n_m2) ? FIN : DRAIN;
        // A pending command holds; after acceptance the next row is checked so issue stays back-to-back.
        if (!rd_vld_p1)        rd_vld_nxt = rd_elig(rd_issued, wr_done, n_ext);
        else if (RD_CMD_READY) rd_vld_nxt = rd_elig(rd_issued + 17'd1, wr_done, n_ext);
        else                   rd_vld_nxt = 1'b1;
        if (!wr_vld_p1)        wr_vld_nxt = wr_elig(wr_issued, rd_issued, n_m2);
        else if (WR_CMD_READY) wr_vld_nxt = wr_elig(wr_issued + 17'd1, rd_issued, n_m2);
        else                   wr_vld_nxt = 1'b1;
      end
      DRAIN: if (wr_done == n_m2) state_nxt = FIN;
      FIN:   if (done_q && !STENCIL_GO) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rd_vld_p1 <= 1'b0;
      wr_vld_p1 <= 1'b0;
      done_q    <= 1'b0;
      n_q       <= '0;
      stride_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_issued <= '0;
      wr_issued <= '0;
      wr_done   <= '0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_vld_nxt;
      wr_vld_p1 <= wr_vld_nxt;
      done_q    <= (state == FIN) && (state_nxt == FIN);
      if (state == IDLE && STENCIL_GO) begin
        n_q       <= STENCIL_SIZE;
        stride_q  <= stride_in;
        rd_addr_q <= STENCIL_SRC;
        wr_addr_q <= STENCIL_DST + stride_in;
        rd_issued <= '0;
        wr_issued <= '0;
        wr_done   <= '0;
      end else if (active) begin
        if (rd_hs) begin
          rd_issued <= rd_issued + 17'd1;
          rd_addr_q <= rd_addr_q + stride_q;
        end
        if (wr_hs) begin
          wr_issued <= wr_issued + 17'd1;
          wr_addr_q <= wr_addr_q + stride_q;
        end
        if (WR_CMPL && (wr_done < n_m2)) wr_done <= wr_done + 17'd1;
      end
    end
  end

  assign STENCIL_DONE = done_q;
  assign RD_CMD_VALID = rd_vld_p1;
  assign RD_CMD_ADDR  = rd_addr_q;
  assign RD_CMD_LEN   = n_q;
  assign WR_CMD_VALID = wr_vld_p1;
  assign WR_CMD_ADDR  = wr_addr_q;
  assign WR_CMD_LEN   = n_q;

endmodule
